// File: rtl/sym_packer.sv
// Packs four 2-bit symbols into an 8-bit word with a per-slot written mask.
// Define SYM_PACKER_ADDR_EN to target slots from in_slot instead of an internal fill pointer.
module sym_packer (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_sym,
  input  logic [1:0] in_slot,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [3:0] out_mask
);

  localparam int unsigned SymW  = 2;
  localparam int unsigned Slots = 4;
  localparam int unsigned SlotW = 2;
  localparam int unsigned DataW = SymW * Slots;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [DataW-1:0]   data_q,  data_d;
  logic [Slots-1:0]   mask_q,  mask_d;
  logic [SlotW-1:0]   tgt_c;

`ifdef SYM_PACKER_ADDR_EN
  assign tgt_c = in_slot;
`else
  logic [SlotW-1:0] ptr_q, ptr_d;
  logic             unused_slot;
  assign tgt_c       = ptr_q;
  assign unused_slot = ^in_slot;
`endif

  // State register; reset discards any partial or undrained word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      data_q  <= '0;
      mask_q  <= '0;
`ifndef SYM_PACKER_ADDR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
`ifndef SYM_PACKER_ADDR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Next-state: accept into target slot, complete on full mask or flush, clear on drain.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
`ifndef SYM_PACKER_ADDR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      FILL: begin
        if (in_valid) begin
          for (int unsigned s = 0; s < Slots; s++) begin
            if (tgt_c == SlotW'(s)) begin
              data_d[DataW-1-SymW*s -: SymW] = in_sym;
              mask_d[s]                      = 1'b1;
            end
          end
`ifndef SYM_PACKER_ADDR_EN
          ptr_d = ptr_q + SlotW'(1);
`endif
        end
        // A same-cycle accept makes mask_d nonzero, so flush then includes it.
        if ((mask_d == '1) || (flush && (mask_d != '0))) begin
          state_d = FULL;
`ifndef SYM_PACKER_ADDR_EN
          ptr_d   = '0;
`endif
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d = FILL;
          data_d  = '0;
          mask_d  = '0;
`ifndef SYM_PACKER_ADDR_EN
          ptr_d   = '0;
`endif
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_mask  = mask_q;

endmodule

// File: tb/tb_sym_packer.sv
// Self-checking bench for sym_packer: directed steps plus a word scoreboard.
module tb_sym_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_sym;
  logic [1:0] in_slot;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_mask;

  always #5 clk = ~clk;

  sym_packer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sym    (in_sym),
    .in_slot   (in_slot),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mask  (out_mask)
  );

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  logic [11:0] sb[$];
  logic [7:0]  m_data;
  logic [3:0]  m_mask;
  logic [1:0]  m_ptr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_data = 8'h00;
    m_mask = 4'h0;
    m_ptr  = 2'd0;
  endtask

  task automatic model_emit();
    sb.push_back({m_data, m_mask});
    model_clear();
  endtask

  task automatic send_at(input logic [1:0] sym, input logic [1:0] slot, input logic fl);
    int i;
    chk("in_ready_before_send", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_sym   = sym;
    in_slot  = slot;
    flush    = fl;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    i = 3 - int'(slot);
    m_data[2*i +: 2] = sym;
    m_mask[slot]     = 1'b1;
    m_ptr            = m_ptr + 2'd1;
    if (m_mask == 4'hF || fl) model_emit();
  endtask

  task automatic send(input logic [1:0] sym);
    send_at(sym, m_ptr, 1'b0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    if (m_mask != 4'h0) model_emit();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    model_clear();
  endtask

  // Waits (bounded) for a word, checks it against the scoreboard and, if out_ready, its drain.
  task automatic expect_word(input string tag);
    logic [11:0] exp;
    exp = 12'h000;
    for (int i = 0; i < 8 && !out_valid; i++) tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) exp = sb.pop_front();
    chk({tag, "_data"}, 32'(out_data), 32'(exp[11:4]));
    chk({tag, "_mask"}, 32'(out_mask), 32'(exp[3:0]));
    if (out_ready) begin
      tick();
      chk({tag, "_drain_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_drain_mask"}, 32'(out_mask), 32'd0);
      chk({tag, "_drain_data"}, 32'(out_data), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sym = 2'd0; in_slot = 2'd0;
    flush = 1'b0; out_ready = 1'b1;
    model_clear();
    tick();
    do_reset();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mask", 32'(out_mask), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);

    // Full word 3,2,1,0 -> E4; valid one cycle after fourth accept.
    send(2'd3); send(2'd2); send(2'd1);
    chk("e4_early_valid", 32'(out_valid), 32'd0);
    send(2'd0);
    chk("e4_latency", 32'(out_valid), 32'd1);
    chk("e4_const", 32'(out_data), 32'h0E4);
    expect_word("e4");

    // Partial word flushed alone.
    send(2'd1); send(2'd3);
    do_flush();
    chk("flush_latency", 32'(out_valid), 32'd1);
    chk("flush_const", 32'(out_data), 32'h070);
    expect_word("flush70");

    // Flush with empty mask is ignored.
    do_flush();
    chk("empty_flush_valid", 32'(out_valid), 32'd0);
    tick();
    chk("empty_flush_valid2", 32'(out_valid), 32'd0);
    chk("empty_flush_sb", 32'(sb.size()), 32'd0);

    // Flush together with an accept includes that symbol.
    send_at(2'd2, m_ptr, 1'b1);
    chk("flush_acc_latency", 32'(out_valid), 32'd1);
    expect_word("flush_acc");

    // Backpressure: hold word while inputs in FULL are ignored.
    out_ready = 1'b0;
    send(2'd0); send(2'd1); send(2'd2); send(2'd3);
    in_valid = 1'b1; in_sym = 2'd3; flush = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_data", 32'(out_data), 32'h01B);
      chk("bp_mask", 32'(out_mask), 32'hF);
    end
    in_valid = 1'b0; flush = 1'b0;
    out_ready = 1'b1;
    expect_word("bp");

    // Reset mid-word discards partial contents.
    send(2'd3); send(2'd3);
    do_reset();
    chk("midrst_mask", 32'(out_mask), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    send(2'd0); send(2'd0); send(2'd0); send(2'd1);
    chk("midrst_const", 32'(out_data), 32'h001);
    expect_word("midrst");

    // Reset over an undrained full word discards it.
    out_ready = 1'b0;
    send(2'd1); send(2'd1); send(2'd1); send(2'd1);
    chk("fullrst_pre", 32'(out_valid), 32'd1);
    do_reset();
    chk("fullrst_valid", 32'(out_valid), 32'd0);
    chk("fullrst_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("fullrst_no_emit", 32'(out_valid), 32'd0);

    // Random partial and full words.
    for (int w = 0; w < 6; w++) begin
      int n;
      n = int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) send(2'($urandom_range(0, 3)));
      if (n < 4) do_flush();
      expect_word("rnd");
    end

`ifdef SYM_PACKER_ADDR_EN
    // Addressed writes in arbitrary slot order.
    send_at(2'd1, 2'd3, 1'b0);
    send_at(2'd2, 2'd0, 1'b0);
    send_at(2'd3, 2'd2, 1'b0);
    send_at(2'd0, 2'd1, 1'b0);
    chk("addr_8d", 32'(out_data), 32'h08D);
    expect_word("addr_order");

    // Overwrite leaves mask unchanged and does not complete the word.
    send_at(2'd1, 2'd0, 1'b0);
    send_at(2'd2, 2'd0, 1'b0);
    chk("ovw_mask", 32'(out_mask), 32'h1);
    chk("ovw_data", 32'(out_data), 32'h080);
    chk("ovw_valid", 32'(out_valid), 32'd0);
    send_at(2'd0, 2'd1, 1'b0);
    send_at(2'd0, 2'd2, 1'b0);
    send_at(2'd0, 2'd3, 1'b0);
    chk("ovw_80", 32'(out_data), 32'h080);
    chk("ovw_full_mask", 32'(out_mask), 32'hF);
    expect_word("addr_ovw");
`endif

    chk("sb_leftover", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/sym_packer.md
SYM_PACKER -- requirements
Module: sym_packer

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port in_valid  input  1  producer offers a 2-bit symbol.
REQ-004 SHALL have port in_ready  output  1  packer can accept a symbol this cycle.
REQ-005 SHALL have port in_sym  input  2  symbol data.
REQ-006 SHALL have port in_slot  input  2  target slot address; used only when SYM_PACKER_ADDR_EN is defined, ignored otherwise.
REQ-007 SHALL have port flush  input  1  request to emit a partially filled word.
REQ-008 SHALL have port out_valid  output  1  packed word available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the word.
REQ-010 SHALL have port out_data  output  8  packed word.
REQ-011 SHALL have port out_mask  output  4  bit n set means slot n holds a written symbol.

Function
REQ-012 SHALL map slots to bits as follows: slot 0 to out_data[7:6], slot 1 to [5:4], slot 2 to [3:2], slot 3 to [1:0].
REQ-013 SHALL implement two states, FILL and FULL; in_ready SHALL be 1 exactly in FILL, and out_valid SHALL be 1 exactly in FULL.
REQ-014 SHALL accept a symbol on a cycle where in_valid and in_ready are both 1: write in_sym into the target slot and set that slot's mask bit at the next edge.
REQ-015 SHALL transition FILL to FULL at the edge where the accepted symbol makes out_mask 4'b1111, so out_valid rises one cycle after the fourth accept.
REQ-016 SHALL transition FILL to FULL on flush=1 when out_mask is nonzero or a symbol is accepted in the same cycle; that same-cycle symbol SHALL be included in the word.
REQ-017 SHALL ignore flush when out_mask is 0 and no symbol is accepted, and SHALL ignore flush in FULL.
REQ-018 SHALL hold unwritten slots at 2'b00 in out_data.
REQ-019 SHALL hold out_data and out_mask stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, on out_valid and out_ready both 1, clear out_data and out_mask to 0 and return to FILL at the next edge; in_ready SHALL be 1 on the following cycle. Minimum word period is 5 cycles.
REQ-021 SHALL ignore in_valid, in_sym and in_slot while in FULL (no accept, no state change).

Reset
REQ-022 SHALL, when rst=1 at a clock edge, set the state to FILL, out_data to 8'h00, out_mask to 4'b0000 and the fill pointer to 0, overriding any concurrent accept, flush or drain.
REQ-023 SHALL drive out_valid=0 and in_ready=1 in the first cycle after reset.
REQ-024 SHALL discard a partially filled word or an undrained full word when reset is applied mid-operation, without emitting it.

Configuration
REQ-025 SHALL use the macro SYM_PACKER_ADDR_EN to select the slot-targeting mode.
REQ-026 SHALL, when SYM_PACKER_ADDR_EN is undefined, target a 2-bit fill pointer that starts at 0, increments on each accept, and resets to 0 on drain, flush-emit or reset.
REQ-027 SHALL, when SYM_PACKER_ADDR_EN is defined, target in_slot; a write to an already-set slot overwrites its data, leaves out_mask unchanged and does not advance completion.

Verification
REQ-028 SHALL be verified with SYM_PACKER_ADDR_EN undefined and out_ready=1: accept symbols 3,2,1,0 -> out_valid one cycle after the 4th accept, out_data=8'hE4, out_mask=4'b1111.
REQ-029 SHALL be verified with SYM_PACKER_ADDR_EN undefined: accept 1,3, then pulse flush alone -> next cycle out_data=8'h70, out_mask=4'b0011; pulse flush with mask 0 -> no out_valid.
REQ-030 SHALL be verified for backpressure: complete a word and hold out_ready=0 for 3 cycles -> out_data stable, in_ready=0, in_valid pulses ignored; raise out_ready -> drain, then in_ready=1 with mask 0.
REQ-031 SHALL be verified for mid-word reset: accept 2 symbols, assert rst for 1 cycle, then accept 0,0,0,1 -> single word 8'h01 with no stale bits.
REQ-032 SHALL be verified with SYM_PACKER_ADDR_EN defined: write slot/sym pairs 3/1, 0/2, 2/3, 1/0 -> out_data=8'h8D; a separate run writing slot 0 twice (1 then 2), then slots 1,2,3 with 0 -> out_data=8'h80, out_mask=4'b1111.
